fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one synchronous FIFO (FIFO_WIDTH x FIFO_DEPTH) among NUM_REQ producers. It sits directly in front of the FIFO write port. It grants one producer per cycle and registers the winning word onto the FIFO's wr_en/data_in. A credit counter mirrors FIFO occupancy so the FIFO is never written while full. The arbiter also cross-checks the FIFO's wr_ack/overflow responses and raises a sticky error on mismatch.

---
 rtl/fifo_wr_arbiter.sv | 138 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write-port arbiter in front of a single synchronous FIFO.
//   Each cycle it grants at most one of NUM_REQ producers and registers the
//   winning word onto the FIFO write port. A local credit counter tracks the
//   free FIFO entries so the FIFO is never written while full. The FIFO's
//   wr_ack and overflow responses are cross-checked and a sticky err is raised
//   on any inconsistency.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid        per-producer request
//   req_data         per-producer word, producer i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   req_ready        one-hot grant (combinational), zero when no credit/request
//   fifo_wr_en       registered FIFO write enable
//   fifo_data_in     registered FIFO write data
//   fifo_rd_en       FIFO consumer read enable (credit return)
//   fifo_empty       FIFO empty flag
//   fifo_wr_ack      FIFO write acknowledge, expected one cycle after fifo_wr_en
//   fifo_overflow    FIFO overflow flag
//   grant_id         index of the last accepted producer
//   credits          free entries the arbiter believes remain
//   err              sticky protocol error
//   err_clr          synchronous clear of err (a same-cycle set wins)

module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_rd_en,
  input  logic                          fifo_empty,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [$clog2(FIFO_DEPTH):0]   credits,
  output logic                          err,
  input  logic                          err_clr
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int CR_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CR_W-1:0] CREDIT_MAX = CR_W'(FIFO_DEPTH);
  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       win_id;
  logic                  win_found;
  logic [FIFO_WIDTH-1:0] win_data;
  logic                  has_credit;
  logic                  xfer;
  logic                  rd_ok;
  logic                  ack_pend;
  logic                  ack_miss;
  logic                  credit_ovf;
  logic                  err_set;
  logic [ID_W-1:0]       rr_next;

  // Search starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_w;
    idx       = 0;
    idx_w     = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx   = (int'(rr_ptr) + k) % NUM_REQ;
      idx_w = ID_W'(idx);
      if (!win_found && req_valid[idx_w]) begin
        win_found = 1'b1;
        win_id    = idx_w;
      end
    end
  end

  assign has_credit = (credits != '0);
  assign xfer       = win_found && has_credit;
  assign req_ready  = xfer ? (NUM_REQ'(1) << win_id) : '0;
  assign win_data   = req_data[win_id*FIFO_WIDTH +: FIFO_WIDTH];
  assign rr_next    = (win_id == LAST_ID) ? '0 : win_id + 1'b1;

  assign rd_ok      = fifo_rd_en && !fifo_empty;
  // A returned credit with no matching debit while already at full capacity
  // means the FIFO reported a read the arbiter never wrote.
  assign credit_ovf = rd_ok && !xfer && (credits == CREDIT_MAX);
  assign ack_miss   = ack_pend && !fifo_wr_ack;
  assign err_set    = fifo_overflow || ack_miss || credit_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      grant_id     <= '0;
      rr_ptr       <= '0;
    end else begin
      fifo_wr_en <= xfer;
      if (xfer) begin
        fifo_data_in <= win_data;
        grant_id     <= win_id;
        rr_ptr       <= rr_next;
      end
    end
  end

  // Debit happens in the accept cycle, a cycle before the FIFO count rises,
  // so the credit view is always at or below the true free space.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= CREDIT_MAX;
    end else if (xfer && !rd_ok) begin
      credits <= credits - 1'b1;
    end else if (rd_ok && !xfer && (credits != CREDIT_MAX)) begin
      credits <= credits + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pend <= 1'b0;
      err      <= 1'b0;
    end else begin
      ack_pend <= fifo_wr_en;
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int W = 16;
  localparam int D = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic           fifo_rd_en = 1'b0;
  logic           fifo_empty;
  logic           fifo_wr_ack;
  logic           fifo_overflow = 1'b0;
  logic [1:0]     grant_id;
  logic [3:0]     credits;
  logic           err;
  logic           err_clr = 1'b0;

  // FIFO environment model knobs
  logic ack_kill = 1'b0;
  logic fake_nonempty = 1'b0;
  int   f_cnt;

  int n_cmp = 0;
  int n_err = 0;

  fifo_wr_arbiter #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .fifo_wr_ack(fifo_wr_ack),
    .fifo_overflow(fifo_overflow), .grant_id(grant_id), .credits(credits),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Minimal FIFO: acknowledges each write one cycle after wr_en, tracks count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_cnt       <= 0;
      fifo_wr_ack <= 1'b0;
    end else begin
      fifo_wr_ack <= fifo_wr_en && !ack_kill;
      f_cnt <= f_cnt + (fifo_wr_en ? 1 : 0) - ((fifo_rd_en && f_cnt != 0) ? 1 : 0);
    end
  end
  assign fifo_empty = (f_cnt == 0) && !fake_nonempty;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; fifo_rd_en = 1'b0; fifo_overflow = 1'b0; err_clr = 1'b0;
    ack_kill = 1'b0; fake_nonempty = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %b exp 0", fifo_wr_en); end
    n_cmp++; if (fifo_data_in !== 16'h0) begin n_err++; $display("FAIL rst_data: got %h exp 0000", fifo_data_in); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rst_grant: got %0d exp 0", grant_id); end
    n_cmp++; if (credits !== 4'd8) begin n_err++; $display("FAIL rst_credits: got %0d exp 8", credits); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b exp 0", err); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready_idle: got %b exp 0000", req_ready); end
    req_valid = 4'b1010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rst_ready_req: got %b exp 0010", req_ready); end
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_data  = {16'h0000, 16'hA5A5, 16'h0000, 16'h0000};
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b exp 0100", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en: got %b exp 1", fifo_wr_en); end
    n_cmp++; if (fifo_data_in !== 16'hA5A5) begin n_err++; $display("FAIL single_data: got %h exp a5a5", fifo_data_in); end
    n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_grant: got %0d exp 2", grant_id); end
    n_cmp++; if (credits !== 4'd7) begin n_err++; $display("FAIL single_credits: got %0d exp 7", credits); end
    tick();
    n_cmp++; if (fifo_wr_ack !== 1'b1) begin n_err++; $display("FAIL single_ack: got %b exp 1", fifo_wr_ack); end
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL single_wr_en_off: got %b exp 0", fifo_wr_en); end
    tick();
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL single_err: got %b exp 0", err); end
  endtask

  task automatic test_fill();
    logic [3:0]  exp_ready;
    logic [3:0]  exp_cr;
    logic [1:0]  exp_gid;
    logic [15:0] exp_data;
    do_reset();
    req_data  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      #1;
      exp_ready = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      exp_cr    = (k < 8) ? 4'(8 - k) : 4'd0;
      n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL fill_ready[%0d]: got %b exp %b", k, req_ready, exp_ready); end
      n_cmp++; if (credits !== exp_cr) begin n_err++; $display("FAIL fill_credits[%0d]: got %0d exp %0d", k, credits, exp_cr); end
      tick();
      exp_gid  = (k < 8) ? 2'(k % 4) : 2'd3;
      exp_data = 16'h1000 + 16'(exp_gid);
      n_cmp++; if (fifo_wr_en !== (k < 8)) begin n_err++; $display("FAIL fill_wr_en[%0d]: got %b exp %b", k, fifo_wr_en, (k < 8)); end
      n_cmp++; if (grant_id !== exp_gid) begin n_err++; $display("FAIL fill_grant[%0d]: got %0d exp %0d", k, grant_id, exp_gid); end
      n_cmp++; if (fifo_data_in !== exp_data) begin n_err++; $display("FAIL fill_data[%0d]: got %h exp %h", k, fifo_data_in, exp_data); end
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL fill_err[%0d]: got %b exp 0", k, err); end
    end
  endtask

  // Continues from the full state left by test_fill (credits 0, rr_ptr 0).
  task automatic test_full_boundary();
    req_valid  = '0;
    fifo_rd_en = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL full_ready0: got %b exp 0000", req_ready); end
    tick();
    fifo_rd_en = 1'b0;
    n_cmp++; if (credits !== 4'd1) begin n_err++; $display("FAIL full_credit_ret: got %0d exp 1", credits); end
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL full_ready_p0: got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (credits !== 4'd0) begin n_err++; $display("FAIL full_credits_p0: got %0d exp 0", credits); end
    // rr_ptr is now 1; producers 1 and 3 wait on a full FIFO.
    req_valid  = 4'b1010;
    fifo_rd_en = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL full_ready_blocked: got %b exp 0000", req_ready); end
    tick();
    fifo_rd_en = 1'b0;
    n_cmp++; if (credits !== 4'd1) begin n_err++; $display("FAIL full_credits_1: got %0d exp 1", credits); end
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL full_ready_p1: got %b exp 0010", req_ready); end
    tick();
    n_cmp++; if (credits !== 4'd0) begin n_err++; $display("FAIL full_credits_0: got %0d exp 0", credits); end
    n_cmp++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL full_grant: got %0d exp 1", grant_id); end
    n_cmp++; if (fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL full_wr_en: got %b exp 1", fifo_wr_en); end
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL full_ready_after: got %b exp 0000", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL full_wr_en_off: got %b exp 0", fifo_wr_en); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL full_err: got %b exp 0", err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_data  = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
    req_valid = 4'hF;
    repeat (3) tick();
    n_cmp++; if (credits !== 4'd5) begin n_err++; $display("FAIL b2b_credits5: got %0d exp 5", credits); end
    fifo_rd_en = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL b2b_ready3: got %b exp 1000", req_ready); end
    tick();
    fifo_rd_en = 1'b0;
    n_cmp++; if (credits !== 4'd5) begin n_err++; $display("FAIL b2b_credits_hold: got %0d exp 5", credits); end
    n_cmp++; if (grant_id !== 2'd3) begin n_err++; $display("FAIL b2b_grant3: got %0d exp 3", grant_id); end
    n_cmp++; if (fifo_data_in !== 16'hD003) begin n_err++; $display("FAIL b2b_data3: got %h exp d003", fifo_data_in); end
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL b2b_rr_wrap: got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (credits !== 4'd4) begin n_err++; $display("FAIL b2b_credits4: got %0d exp 4", credits); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL b2b_grant0: got %0d exp 0", grant_id); end
  endtask

  task automatic test_err();
    do_reset();
    fifo_overflow = 1'b1;
    tick();
    fifo_overflow = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_ovf_set: got %b exp 1", err); end
    tick();
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b exp 1", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clr: got %b exp 0", err); end
    fifo_overflow = 1'b1; err_clr = 1'b1;
    tick();
    fifo_overflow = 1'b0; err_clr = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set_wins: got %b exp 1", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clr2: got %b exp 0", err); end
    // Missing write acknowledge
    ack_kill  = 1'b1;
    req_data  = {16'h0, 16'h0, 16'h0, 16'h5A5A};
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_ack_early: got %b exp 0", err); end
    tick();
    ack_kill = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_ack_miss: got %b exp 1", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    fifo_rd_en = 1'b1;
    tick();
    fifo_rd_en = 1'b0;
    n_cmp++; if (credits !== 4'd8) begin n_err++; $display("FAIL err_credits_back: got %0d exp 8", credits); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clean: got %b exp 0", err); end
    // Credit return while already at FIFO_DEPTH
    fake_nonempty = 1'b1; fifo_rd_en = 1'b1;
    tick();
    fake_nonempty = 1'b0; fifo_rd_en = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_credit_sat: got %b exp 1", err); end
    n_cmp++; if (credits !== 4'd8) begin n_err++; $display("FAIL err_credit_cap: got %0d exp 8", credits); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req_valid = 4'hF;
    repeat (5) tick();
    req_valid = '0;
    n_cmp++; if (fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL mid_wr_en_pre: got %b exp 1", fifo_wr_en); end
    n_cmp++; if (credits !== 4'd3) begin n_err++; $display("FAIL mid_credits_pre: got %0d exp 3", credits); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL mid_wr_en: got %b exp 0", fifo_wr_en); end
    n_cmp++; if (fifo_data_in !== 16'h0) begin n_err++; $display("FAIL mid_data: got %h exp 0000", fifo_data_in); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL mid_grant: got %0d exp 0", grant_id); end
    n_cmp++; if (credits !== 4'd8) begin n_err++; $display("FAIL mid_credits: got %0d exp 8", credits); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL mid_err: got %b exp 0", err); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL mid_no_ack_err: got %b exp 0", err); end
    n_cmp++; if (credits !== 4'd8) begin n_err++; $display("FAIL mid_credits_after: got %0d exp 8", credits); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_boundary();
    test_back_to_back();
    test_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "timeout");
  end

endmodule
